// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB slot bundle plus the register file write port.
//   mem_valid_i/mem_wreg_i/mem_waddr_i/mem_wdata_i/mem_load_op_i/mem_addr_lo_i
//     : slot presented by the MEM stage
//   wb_we_o/wb_waddr_o/wb_wdata_o : register file write port driven by WB
// master = MEM-stage / regfile side, slave = wb_stage.
interface wb_stage_if;
  logic        mem_valid_i;
  logic        mem_wreg_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  mem_load_op_i;
  logic [1:0]  mem_addr_lo_i;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;

  modport master (
    output mem_valid_i, mem_wreg_i, mem_waddr_i, mem_wdata_i,
           mem_load_op_i, mem_addr_lo_i,
    input  wb_we_o, wb_waddr_o, wb_wdata_o
  );

  modport slave (
    input  mem_valid_i, mem_wreg_i, mem_waddr_i, mem_wdata_i,
           mem_load_op_i, mem_addr_lo_i,
    output wb_we_o, wb_waddr_o, wb_wdata_o
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: write-back stage. Registers the MEM slot, aligns and extends
// load data from the synchronous data RAM (big-endian), drives the register
// file write port, flags misaligned loads and counts retired instructions.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   flush_i        : turn the incoming slot into a bubble
//   stall_i        : hold all slot state
//   bus            : wb_stage_if.slave (MEM slot in, regfile write port out)
//   ram_rdata_i    : RAM read data for the load currently in WB
//   misalign_o     : current slot is a misaligned load
//   retired_o      : count of instructions leaving WB (wraps)
module wb_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             stall_i,
  wb_stage_if.slave        bus,
  input  logic [31:0]      ram_rdata_i,
  output logic             misalign_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } load_op_e;

  logic        valid;
  logic        wreg;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  load_op;
  logic [1:0]  addr_lo;

  logic        hold_vld;
  logic [31:0] hold_data;

  logic        is_load;
  logic        misaligned;
  logic [31:0] src;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  always_comb begin
    is_load = (load_op >= LD_LB) && (load_op <= LD_LW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      wreg      <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      load_op   <= LD_NONE;
      addr_lo   <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
      retired_o <= '0;
    end else begin
      if (flush_i) begin
        valid    <= 1'b0;
        wreg     <= 1'b0;
        waddr    <= '0;
        wdata    <= '0;
        load_op  <= LD_NONE;
        addr_lo  <= '0;
        hold_vld <= 1'b0;
      end else if (stall_i) begin
        // The RAM only presents the word for one cycle; latch it on the
        // first stalled edge so the write data stays stable while held.
        if (!hold_vld && is_load) begin
          hold_data <= ram_rdata_i;
          hold_vld  <= 1'b1;
        end
      end else begin
        hold_vld <= 1'b0;
        if (bus.mem_valid_i) begin
          valid   <= 1'b1;
          wreg    <= bus.mem_wreg_i;
          waddr   <= bus.mem_waddr_i;
          wdata   <= bus.mem_wdata_i;
          load_op <= bus.mem_load_op_i;
          addr_lo <= bus.mem_addr_lo_i;
        end else begin
          valid   <= 1'b0;
          wreg    <= 1'b0;
          waddr   <= '0;
          wdata   <= '0;
          load_op <= LD_NONE;
          addr_lo <= '0;
        end
      end

      if (valid && !stall_i && !flush_i) begin
        retired_o <= retired_o + CNT_W'(1);
      end
    end
  end

  // Big-endian lanes: byte 0 is [31:24], halfword 0 is [31:16].
  always_comb begin
    src = hold_vld ? hold_data : ram_rdata_i;
    case (addr_lo)
      2'd0:    sel_byte = src[31:24];
      2'd1:    sel_byte = src[23:16];
      2'd2:    sel_byte = src[15:8];
      default: sel_byte = src[7:0];
    endcase
    sel_half = addr_lo[1] ? src[15:0] : src[31:16];

    case (load_op)
      LD_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  load_data = {24'd0, sel_byte};
      LD_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  load_data = {16'd0, sel_half};
      LD_LW:   load_data = src;
      default: load_data = wdata;
    endcase

    misaligned = ((load_op == LD_LH || load_op == LD_LHU) && addr_lo[0]) ||
                 ((load_op == LD_LW) && (addr_lo != 2'd0));
  end

  always_comb begin
    bus.wb_we_o    = valid && wreg && !misaligned && (waddr != 5'd0);
    bus.wb_waddr_o = waddr;
    bus.wb_wdata_o = is_load ? load_data : wdata;
    misalign_o     = valid && misaligned;
  end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed, table-driven bench for wb_stage plus hand-written
// sequences for stall hold, flush and reset-during-stall. The counter is
// built 4 bits wide so its wrap is exercised.
module tb_wb_stage;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          stall_i;
  logic [31:0]   ram_rdata_i;
  logic          misalign_o;
  logic [CW-1:0] retired_o;

  wb_stage_if bus ();

  wb_stage #(.CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .stall_i     (stall_i),
    .bus         (bus),
    .ram_rdata_i (ram_rdata_i),
    .misalign_o  (misalign_o),
    .retired_o   (retired_o)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic          slot_v  = 1'b0;
  logic [CW-1:0] exp_ret = '0;

  typedef struct {
    logic        v;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [31:0] rd;
    logic        ewe;
    logic [4:0]  ewa;
    logic [31:0] ewd;
    logic        ecd;
    logic        emis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock edge; keeps the expected retired count in step with the
  // inputs applied before the edge.
  task automatic step();
    if (rst) exp_ret = '0;
    else if (!flush_i && !stall_i && slot_v) exp_ret = exp_ret + 1'b1;
    if (rst || flush_i) slot_v = 1'b0;
    else if (!stall_i) slot_v = bus.mem_valid_i;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [2:0] op, input logic [1:0] lo);
    bus.mem_valid_i   = v;
    bus.mem_wreg_i    = wr;
    bus.mem_waddr_i   = wa;
    bus.mem_wdata_i   = wd;
    bus.mem_load_op_i = op;
    bus.mem_addr_lo_i = lo;
  endtask

  initial begin
    // v wr wa wd op lo rd | we wa wd chk_wd mis
    vecs.push_back('{1,1,5'd5, 32'h1234_5678,3'd0,2'd0,32'h0000_0000, 1,5'd5, 32'h1234_5678,1,0});
    vecs.push_back('{1,1,5'd7, 32'h0,        3'd1,2'd0,32'h80F1_7F02, 1,5'd7, 32'hFFFF_FF80,1,0});
    vecs.push_back('{1,1,5'd8, 32'h0,        3'd2,2'd1,32'h80F1_7F02, 1,5'd8, 32'h0000_00F1,1,0});
    vecs.push_back('{1,1,5'd9, 32'h0,        3'd3,2'd2,32'h80F1_7F02, 1,5'd9, 32'h0000_7F02,1,0});
    vecs.push_back('{1,1,5'd10,32'h0,        3'd4,2'd0,32'h80F1_7F02, 1,5'd10,32'h0000_80F1,1,0});
    vecs.push_back('{1,1,5'd11,32'h0,        3'd5,2'd0,32'h80F1_7F02, 1,5'd11,32'h80F1_7F02,1,0});
    vecs.push_back('{1,1,5'd3, 32'h0,        3'd5,2'd1,32'h80F1_7F02, 0,5'd3, 32'h80F1_7F02,1,1});
    vecs.push_back('{1,1,5'd4, 32'h0,        3'd3,2'd3,32'h80F1_7F02, 0,5'd4, 32'h0000_7F02,1,1});
    vecs.push_back('{0,1,5'd6, 32'h0000_0099,3'd0,2'd0,32'h80F1_7F02, 0,5'd0, 32'h0000_0000,1,0});
    vecs.push_back('{1,1,5'd0, 32'hDEAD_BEEF,3'd0,2'd0,32'h80F1_7F02, 0,5'd0, 32'h0000_0000,0,0});
    vecs.push_back('{1,1,5'd12,32'h0,        3'd1,2'd3,32'h1122_337F, 1,5'd12,32'h0000_007F,1,0});
    vecs.push_back('{1,1,5'd13,32'h0,        3'd2,2'd2,32'h1122_F37F, 1,5'd13,32'h0000_00F3,1,0});
    vecs.push_back('{1,0,5'd14,32'h0,        3'd4,2'd2,32'h1122_F37F, 0,5'd14,32'h0000_F37F,1,0});
    vecs.push_back('{1,1,5'd15,32'h0BAD_F00D,3'd6,2'd1,32'h1122_F37F, 1,5'd15,32'h0BAD_F00D,1,0});
    vecs.push_back('{1,1,5'd16,32'h0,        3'd3,2'd0,32'hC001_2345, 1,5'd16,32'hFFFF_C001,1,0});
    vecs.push_back('{1,1,5'd17,32'h0000_0017,3'd0,2'd0,32'h0,         1,5'd17,32'h0000_0017,1,0});

    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    ram_rdata_i = $urandom();
    drive(1'b1, 1'b1, 5'($urandom_range(31)), $urandom(), 3'($urandom_range(7)), 2'($urandom_range(3)));
    step();
    flush_i = 1'($urandom_range(1));
    drive(1'b1, 1'b1, 5'($urandom_range(31)), $urandom(), 3'd1, 2'($urandom_range(3)));
    step();
    chk("rst_we", bus.wb_we_o, 0);
    chk("rst_waddr", bus.wb_waddr_o, 0);
    chk("rst_wdata", bus.wb_wdata_o, 0);
    chk("rst_mis", misalign_o, 0);
    chk("rst_ret", retired_o, 0);
    rst = 1'b0; flush_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0);
    step();

    // Table-driven single-slot vectors, twice round so the counter wraps.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < vecs.size(); i++) begin
        drive(vecs[i].v, vecs[i].wr, vecs[i].wa, vecs[i].wd, vecs[i].op, vecs[i].lo);
        step();
        ram_rdata_i = vecs[i].rd;
        #1;
        chk($sformatf("v%0d_we", i), bus.wb_we_o, vecs[i].ewe);
        chk($sformatf("v%0d_waddr", i), bus.wb_waddr_o, vecs[i].ewa);
        if (vecs[i].ecd) chk($sformatf("v%0d_wdata", i), bus.wb_wdata_o, vecs[i].ewd);
        chk($sformatf("v%0d_mis", i), misalign_o, vecs[i].emis);
        chk($sformatf("v%0d_ret", i), retired_o, exp_ret);
      end
    end

    // Stall hold: load word captured once, later RAM changes ignored.
    drive(1'b1, 1'b1, 5'd13, 32'h0, 3'd1, 2'd3);
    step();
    ram_rdata_i = 32'h0000_00AA;
    stall_i = 1'b1;
    drive(1'b1, 1'b1, 5'd20, 32'hCAFE_0020, 3'd0, 2'd0);
    #1;
    chk("stall_pre_wdata", bus.wb_wdata_o, 32'hFFFF_FFAA);
    for (int k = 0; k < 3; k++) begin
      step();
      ram_rdata_i = 32'h5555_5555;
      #1;
      chk($sformatf("stall%0d_wdata", k), bus.wb_wdata_o, 32'hFFFF_FFAA);
      chk($sformatf("stall%0d_we", k), bus.wb_we_o, 1);
      chk($sformatf("stall%0d_waddr", k), bus.wb_waddr_o, 13);
      chk($sformatf("stall%0d_ret", k), retired_o, exp_ret);
    end
    stall_i = 1'b0;
    step();
    chk("release_waddr", bus.wb_waddr_o, 20);
    chk("release_wdata", bus.wb_wdata_o, 32'hCAFE_0020);
    chk("release_ret", retired_o, exp_ret);

    // Flush together with stall: flush wins, slot does not retire.
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0);
    #1;
    chk("flstall_we", bus.wb_we_o, 0);
    chk("flstall_waddr", bus.wb_waddr_o, 0);
    chk("flstall_ret", retired_o, exp_ret);

    // Flush alone on a valid slot.
    drive(1'b1, 1'b1, 5'd21, 32'h21, 3'd0, 2'd0);
    step();
    flush_i = 1'b1;
    drive(1'b1, 1'b1, 5'd22, 32'h22, 3'd0, 2'd0);
    step();
    flush_i = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0);
    #1;
    chk("flush_we", bus.wb_we_o, 0);
    chk("flush_waddr", bus.wb_waddr_o, 0);
    chk("flush_ret", retired_o, exp_ret);

    // Reset in the middle of a stalled load; the captured word must not leak.
    drive(1'b1, 1'b1, 5'd13, 32'h0, 3'd1, 2'd3);
    step();
    ram_rdata_i = 32'h0000_00AA;
    stall_i = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0);
    step();
    ram_rdata_i = 32'h5555_5555;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rststall_we", bus.wb_we_o, 0);
    chk("rststall_wdata", bus.wb_wdata_o, 0);
    chk("rststall_mis", misalign_o, 0);
    chk("rststall_ret", retired_o, 0);
    stall_i = 1'b0;
    drive(1'b1, 1'b1, 5'd14, 32'h0, 3'd2, 2'd3);
    step();
    ram_rdata_i = 32'h0000_00CC;
    #1;
    chk("postrst_wdata", bus.wb_wdata_o, 32'h0000_00CC);
    chk("postrst_we", bus.wb_we_o, 1);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 3'd0, 2'd0);
    step();
    chk("postrst_ret", retired_o, exp_ret);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
